alu_byte_sequencer: RTL

//  Multi-byte operation sequencer for the shared 8-bit ALU (two cascaded 74181 slices).

---
 rtl/alu_byte_sequencer_if.sv | 46 ++++
 rtl/alu_byte_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alu_byte_sequencer_if.sv
// Bus bundle between the host register file, the byte sequencer and the shared 8-bit ALU.
//   Request side : start, abort, op_a, op_b, op_s, op_m, op_cn (host -> sequencer)
//   Status side  : busy, done, result, cout, eq_all            (sequencer -> host)
//   ALU side     : alu_a, alu_b, alu_s, alu_m, alu_cn          (sequencer -> ALU)
//                  alu_f, alu_cn8, alu_eq                      (ALU -> sequencer)
// The slave modport is the sequencer. The master modport is its environment.
interface alu_byte_sequencer_if #(
  parameter int unsigned NUM_BYTES = 4
);
  logic                   start;
  logic                   abort;
  logic [NUM_BYTES*8-1:0] op_a;
  logic [NUM_BYTES*8-1:0] op_b;
  logic [3:0]             op_s;
  logic                   op_m;
  logic                   op_cn;

  logic [7:0]             alu_a;
  logic [7:0]             alu_b;
  logic [3:0]             alu_s;
  logic                   alu_m;
  logic                   alu_cn;
  logic [7:0]             alu_f;
  logic                   alu_cn8;
  logic                   alu_eq;

  logic                   busy;
  logic                   done;
  logic [NUM_BYTES*8-1:0] result;
  logic                   cout;
  logic                   eq_all;

  modport slave (
    input  start, abort, op_a, op_b, op_s, op_m, op_cn,
    output alu_a, alu_b, alu_s, alu_m, alu_cn,
    input  alu_f, alu_cn8, alu_eq,
    output busy, done, result, cout, eq_all
  );

  modport master (
    output start, abort, op_a, op_b, op_s, op_m, op_cn,
    input  alu_a, alu_b, alu_s, alu_m, alu_cn,
    output alu_f, alu_cn8, alu_eq,
    input  busy, done, result, cout, eq_all
  );
endinterface

// File: rtl/alu_byte_sequencer.sv
// Multi-byte operation sequencer for the shared 8-bit ALU (two cascaded 74181 slices).
// Latches wide operands on start, feeds the ALU one byte per cycle LSB first while
// chaining the raw (active-low) carry, collects result/cout/eq_all and pulses done.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   ena  - clock enable; when low all state and outputs hold
//   bus  - alu_byte_sequencer_if.slave (request, status and ALU-side signals)
module alu_byte_sequencer #(
  parameter int unsigned NUM_BYTES = 4
) (
  input logic                clk,
  input logic                rst,
  input logic                ena,
  alu_byte_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);
  // Byte-select width; idx never reaches NUM_BYTES while in RUN.
  localparam int unsigned SEL_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [NUM_BYTES-1:0][7:0]  a_q, a_d;
  logic [NUM_BYTES-1:0][7:0]  b_q, b_d;
  logic [NUM_BYTES-1:0][7:0]  res_q, res_d;
  logic [3:0]                 s_q, s_d;
  logic                       m_q, m_d;
  logic                       carry_q, carry_d;
  logic                       eq_q, eq_d;
  logic                       cout_q, cout_d;
  logic                       eq_all_q, eq_all_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [SEL_W-1:0]           sel;
  logic                       run;

  assign sel = idx_q[SEL_W-1:0];
  assign run = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    cout_d   = cout_q;
    eq_all_d = eq_all_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        // start takes priority over abort here: abort only matters in RUN.
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          s_d     = bus.op_s;
          m_d     = bus.op_m;
          carry_d = bus.op_cn;
          idx_d   = '0;
          eq_d    = 1'b1;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          res_d[sel] = bus.alu_f;
          carry_d    = bus.alu_cn8;
          eq_d       = eq_q & bus.alu_eq;
          idx_d      = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            // Register the flags now so they are stable through DONE and afterwards.
            cout_d   = bus.alu_cn8;
            eq_all_d = eq_q & bus.alu_eq;
            state_d  = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      cout_q   <= 1'b0;
      eq_all_q <= 1'b0;
      idx_q    <= '0;
    end else if (ena) begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      cout_q   <= cout_d;
      eq_all_q <= eq_all_d;
      idx_q    <= idx_d;
    end
  end

  // Operand bytes and carry are only presented while sequencing; select/mode stay latched.
  assign bus.alu_a  = run ? a_q[sel] : 8'h00;
  assign bus.alu_b  = run ? b_q[sel] : 8'h00;
  assign bus.alu_cn = run ? carry_q : 1'b0;
  assign bus.alu_s  = s_q;
  assign bus.alu_m  = m_q;

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.eq_all = eq_all_q;

endmodule
